// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word extend and
// read-modify-write, byte-order conversion to the memory port.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        _mem_read,
  output logic        _mem_write,
  input  logic [31:0] mem_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  logic [1:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        fault_q, fault_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  // word_q: store data to write, or the finished load result
  logic [31:0] word_q, word_d;

  logic [31:0] mem_word;
  logic [31:0] load_ext;
  logic [31:0] store_merge;

  assign mem_word = {mem_out[7:0], mem_out[15:8],
                     mem_out[23:16], mem_out[31:24]};

  always_comb begin
    load_ext = mem_word;
    unique case (size_q)
      2'b00: load_ext = signed_q ? {{24{mem_word[7]}}, mem_word[7:0]}
                                 : {24'd0, mem_word[7:0]};
      2'b01: load_ext = signed_q ? {{16{mem_word[15]}}, mem_word[15:0]}
                                 : {16'd0, mem_word[15:0]};
      default: load_ext = mem_word;
    endcase
  end

  always_comb begin
    store_merge = mem_word;
    unique case (size_q)
      2'b00:   store_merge = {mem_word[31:8], wdata_q[7:0]};
      2'b01:   store_merge = {mem_word[31:16], wdata_q};
      default: store_merge = mem_word;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    fault_d  = fault_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_address;
          wdata_d  = req_wdata[15:0];
          word_d   = req_wdata;
          fault_d  = (req_size == 2'b11) || (req_address > MAX_ADDR);
          if (fault_d)
            state_d = S_RESP;
          else if (req_write && req_size == 2'b10)
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        word_d  = write_q ? store_merge : load_ext;
        state_d = write_q ? S_WR : S_RESP;
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      fault_q  <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 16'd0;
      word_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      fault_q  <= fault_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
    end
  end

  // Every output is gated by rst so a reset cycle is quiet
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP) && !rst;
  assign resp_fault = resp_valid && fault_q;
  assign resp_rdata = (resp_valid && !fault_q && !write_q) ? word_q : 32'd0;
  assign _mem_read  = (state_q == S_RD) && !rst;
  assign _mem_write = (state_q == S_WR) && !rst;

  assign mem_address    = (_mem_read || _mem_write) ? addr_q : 32'd0;
  assign mem_write_data = _mem_write ? word_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural memory,
// a byte-array reference model and a response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_out;

  int total = 0;
  int bad   = 0;
  int acc   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] mem     [0:1023];
  logic [7:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_address(req_address),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    ._mem_read(mem_rd), ._mem_write(mem_wr),
    .mem_out(mem_out)
  );

  logic [9:0] ma;
  always_comb begin
    ma = mem_address[9:0];
    mem_out = {mem[ma], mem[10'(ma + 10'd1)],
               mem[10'(ma + 10'd2)], mem[10'(ma + 10'd3)]};
  end

  always @(posedge clk) begin
    if (mem_wr)
      for (int k = 0; k < 4; k++)
        mem[10'(ma + 10'(k))] = mem_write_data[8*k +: 8];
  end

  always @(posedge clk)
    if (req_valid && req_ready) acc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  function automatic logic [31:0] ref_load(input int a,
      input logic [1:0] sz, input logic sg);
    logic [31:0] w;
    w = ref_word(a);
    if (sz == 2'b00) return sg ? {{24{w[7]}}, w[7:0]} : {24'd0, w[7:0]};
    if (sz == 2'b01) return sg ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
    return w;
  endfunction

  task automatic ref_store(input int a, input logic [1:0] sz,
                           input logic [31:0] d);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[a+k] = d[8*k +: 8];
  endtask

  task automatic issue(input logic w, input logic [1:0] sz,
      input logic sg, input logic [31:0] a, input logic [31:0] d,
      input logic keep);
    exp_t e;
    logic f;
    logic got;
    f = (sz == 2'b11) || (a > 32'd1020);
    e.fault = f;
    e.rdata = (f || w) ? 32'd0 : ref_load(int'(a), sz, sg);
    e.lat   = f ? 1 : (w && sz != 2'b10) ? 3 : 2;
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz;
    req_signed = sg; req_address = a; req_wdata = d;
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_address = $urandom;
    req_wdata = $urandom;
    if (!f && w) ref_store(int'(a), sz, d);
    got = 1'b0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        exp_t x;
        got = 1'b1;
        x = sbq.pop_front();
        chk("resp_rdata", resp_rdata, x.rdata);
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, x.fault});
        chk("latency", 32'(n), 32'(x.lat));
        chk("resp_ready", {31'd0, req_ready}, 32'd0);
      end else begin
        logic er, ew;
        er = !f && !(w && sz == 2'b10) && n == 1;
        ew = !f && w && n == e.lat - 1;
        chk("busy_ready", {31'd0, req_ready}, 32'd0);
        chk("mem_read", {31'd0, mem_rd}, {31'd0, er});
        chk("mem_write", {31'd0, mem_wr}, {31'd0, ew});
        if (er || ew) chk("mem_address", mem_address, a);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $error("FAIL resp_timeout observed=none expected=resp_valid");
      void'(sbq.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_address = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_mem_rw", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("word_val", ref_word(16), 32'hDEADBEEF);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("rmw_val", ref_word(16), 32'hDEAD55EF);

    issue(1'b0, 2'b10, 1'b0, 32'd1021, 32'h0, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'd1023, 32'hA5A5A5A5, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'd1020, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1'b0);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01;
    req_signed = 1'b0; req_address = 32'h20; req_wdata = 32'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_phase", {31'd0, mem_rd}, 32'd1);
    @(negedge clk);
    chk("rmw_wr_phase", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    #1;
    chk("wr_gated", {31'd0, mem_wr}, 32'd0);
    @(negedge clk);
    chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("abort_ready_rst", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_no_resp2", {31'd0, resp_valid}, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

    begin
      int a0;
      a0 = acc;
      for (int i = 0; i < 6; i++) begin
        logic [31:0] ad;
        ad = 32'h40 + 32'(4 * (i / 2));
        if (i % 2 == 0)
          issue(1'b1, 2'(i % 3), 1'b0, ad, 32'h11111111 * 32'(i + 1), 1'b1);
        else
          issue(1'b0, 2'b10, 1'b0, ad, 32'h0, 1'b1);
      end
      req_valid = 1'b0;
      chk("accept_count", 32'(acc - a0), 32'd6);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
